led_pulse_stretch: RTL and testbench

LED_PULSE_STRETCH -- requirements
Module: led_pulse_stretch

---
 rtl/led_pulse_stretch.sv | 79 +++++++
 tb/tb_led_pulse_stretch.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: queues one-cycle events and plays each as a fixed-length LED flash followed by a forced off-gap
// ports: clk/rst (async active-high) clock and reset; ev one event per high cycle; clr_ovf clears overflow;
//        led flash drive; busy FSM not idle; pending queued flashes; overflow sticky dropped-event flag
module led_pulse_stretch #(
  parameter int TICK_WIDTH = 21,
  parameter logic [TICK_WIDTH-1:0] TICK_DIVIDE = 21'd2000000,
  parameter int ON_TICKS = 5,
  parameter int OFF_TICKS = 5,
  parameter int PEND_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev,
  input  logic                  clr_ovf,
  output logic                  led,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_DIVIDE - 1'b1;
  localparam logic [7:0] ON_LAST = 8'(ON_TICKS - 1);
  localparam logic [7:0] OFF_LAST = 8'(OFF_TICKS - 1);
  localparam logic [PEND_WIDTH-1:0] PMAX = '1;
  state_t                  state_q;
  logic [TICK_WIDTH-1:0]   cnt_q;
  logic [7:0]              phase_q;
  logic [PEND_WIDTH-1:0]   pend_q, pend_d;
  logic                    ovf_q, ovf_d, led_q, busy_q;
  logic                    consume, tick, sat, last;
  always_comb begin
    consume = (state_q == IDLE) && (pend_q != '0);
    tick    = cnt_q == TICK_LAST;
    sat     = ev && !consume && (pend_q == PMAX);
    pend_d  = sat                ? pend_q :
              (ev && !consume)   ? pend_q + 1'b1 :
              (!ev && consume)   ? pend_q - 1'b1 : pend_q;
    // a new overflow outranks a same-cycle clear
    ovf_d   = sat | (ovf_q & ~clr_ovf);
    last    = (state_q == ON) ? (phase_q == ON_LAST) : (phase_q == OFF_LAST);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (state_q == IDLE) begin
        cnt_q   <= '0;
        phase_q <= '0;
        if (consume) begin
          state_q <= ON;
          led_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
      end else if (!tick) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q   <= '0;
        phase_q <= last ? '0 : phase_q + 1'b1;
        if (last) begin
          state_q <= (state_q == ON) ? GAP : IDLE;
          led_q   <= 1'b0;
          busy_q  <= state_q == ON;
        end
      end
    end
  end
  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb_led_pulse_stretch: directed stimulus with a flash scoreboard for led_pulse_stretch
module tb_led_pulse_stretch;
  logic clk = 1'b0, rst = 1'b1, ev = 1'b0, clr_ovf = 1'b0;
  logic led, busy, overflow;
  logic [1:0] pending;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int len; int gap;} flash_t;
  flash_t exp_q[$];
  led_pulse_stretch #(
    .TICK_WIDTH(21), .TICK_DIVIDE(21'd4), .ON_TICKS(2), .OFF_TICKS(1), .PEND_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .ev(ev), .clr_ovf(clr_ovf),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask
  int rise_t = 0, fall_t = 0, gap_cur = 0;
  logic led_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) led_prev = 1'b0;
    else begin
      if (led && !led_prev) begin
        rise_t  = cyc;
        gap_cur = cyc - fall_t;
      end
      if (!led && led_prev) begin
        fall_t = cyc;
        if (exp_q.size() == 0) chk("extra_flash", exp_q.size(), 1);
        else begin
          flash_t e;
          e = exp_q.pop_front();
          chk("on_len", cyc - rise_t, e.len);
          if (e.gap >= 0) chk("off_gap", gap_cur, e.gap);
        end
      end
      led_prev = led;
    end
  end
  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || pending != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", k < budget, 1);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    // single event
    @(negedge clk); ev = 1'b1; exp_q.push_back('{8, -1});
    @(negedge clk); ev = 1'b0;
    chk("t1_pend1", pending, 1);
    chk("t1_led_e1", led, 0);
    @(negedge clk);
    chk("t1_led_e2", led, 1);
    chk("t1_pend0", pending, 0);
    n = 0;
    do begin
      n++;
      @(negedge clk);
    end while (busy && n < 100);
    chk("t1_busy_len", n, 12);
    chk("t1_pend_end", pending, 0);
    chk("t1_ovf", overflow, 0);
    // five back-to-back events saturate the queue
    exp_q.push_back('{8, -1});
    repeat (3) exp_q.push_back('{8, 5});
    ev = 1'b1;
    repeat (5) @(negedge clk);
    ev = 1'b0;
    chk("t2_pend_peak", pending, 3);
    chk("t2_ovf_set", overflow, 1);
    wait_idle(200);
    chk("t2_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("t2_ovf_clr", overflow, 0);
    // event during an active flash only queues
    @(negedge clk); ev = 1'b1; exp_q.push_back('{8, -1});
    @(negedge clk); ev = 1'b0;
    @(negedge clk);
    chk("t3_led_on", led, 1);
    repeat (2) @(negedge clk);
    ev = 1'b1; exp_q.push_back('{8, 5});
    @(negedge clk); ev = 1'b0;
    chk("t3_pend_q", pending, 1);
    wait_idle(200);
    // reset mid-flash with two queued
    @(negedge clk); ev = 1'b1;
    repeat (3) @(negedge clk);
    ev = 1'b0;
    chk("t4_pend2", pending, 2);
    chk("t4_led_on", led, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_led_async", led, 0);
    chk("t4_busy_async", busy, 0);
    chk("t4_pend_async", pending, 0);
    chk("t4_ovf_async", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (led || busy) n++;
    end
    chk("t4_no_flash", n, 0);
    // saturating event alongside clr_ovf
    exp_q.push_back('{8, -1});
    repeat (3) exp_q.push_back('{8, 5});
    ev = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_pend_full", pending, 3);
    chk("t5_ovf_pre", overflow, 0);
    clr_ovf = 1'b1;
    @(negedge clk); ev = 1'b0;
    chk("t5_ovf_wins", overflow, 1);
    chk("t5_pend_sat", pending, 3);
    @(negedge clk); clr_ovf = 1'b0;
    chk("t5_ovf_clr", overflow, 0);
    wait_idle(300);
    repeat (3) @(negedge clk);
    chk("flashes_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
